// File: rtl/float_to_fixed_seq.sv
// float_to_fixed_seq
//   Converts an IEEE-754 single-precision operand into a 32-bit two's
//   complement fixed-point value Q(31-FRAC_BITS).FRAC_BITS. The result feeds
//   the CORDIC datapath. The block uses the custom-instruction handshake.
//   Alignment uses an iterative shifter that moves up to STEP bits per enabled
//   cycle. This keeps the shifter small.
//
// Ports
//   clock   in   rising-edge clock
//   reset   in   asynchronous active-low reset
//   clk_en  in   global enable; 0 freezes all state (done/result included)
//   start   in   request, accepted only in IDLE
//   dataa   in   [31:0] float operand, captured on the accepting edge
//   result  out  [31:0] fixed-point result, holds between operations
//   done    out  one-enabled-cycle pulse; result valid while high
module float_to_fixed_seq #(
  parameter int FRAC_BITS = 22,
  parameter int STEP      = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic [31:0] result,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, DECODE, SHIFT, FIN} state_t;

  // Bias removal and the 23-bit mantissa offset are folded into one constant.
  localparam logic signed [9:0] SH_OFF = 10'(FRAC_BITS - 150);
  localparam logic [9:0]        STEP_W = 10'(STEP);

  state_t      state_q, state_d;
  logic [31:0] data_q;
  logic [31:0] mag_q;
  logic [31:0] spec_val_q;
  logic        spec_q;
  logic        left_q;
  logic [9:0]  rem_q;

  logic              sign_w;
  logic [7:0]        e_w;
  logic [22:0]       frac_w;
  logic signed [9:0] sh_w;
  logic [9:0]        sh_abs_w;
  logic [31:0]       sat_w;
  logic              is_spec;
  logic [31:0]       spec_val;
  logic [9:0]        k_w;

  assign sign_w   = data_q[31];
  assign e_w      = data_q[30:23];
  assign frac_w   = data_q[22:0];
  assign sh_w     = $signed({2'b00, e_w}) + SH_OFF;
  assign sh_abs_w = sh_w[9] ? 10'(-sh_w) : 10'(sh_w);
  assign sat_w    = sign_w ? 32'h8000_0000 : 32'h7FFF_FFFF;

  // Once sh exceeds 7, m<<sh no longer fits in 31 magnitude bits.
  // Once sh is below -24, all 24 mantissa bits are shifted out.
  always_comb begin
    is_spec  = 1'b1;
    spec_val = '0;
    if (e_w == 8'd0)
      spec_val = '0;
    else if (e_w == 8'hFF)
      spec_val = (frac_w != '0) ? 32'h0 : sat_w;
    else if (sh_w > 10'sd7)
      spec_val = sat_w;
    else if (sh_w < -10'sd24)
      spec_val = '0;
    else
      is_spec = 1'b0;
  end

  assign k_w = (rem_q < STEP_W) ? rem_q : STEP_W;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      state_q <= IDLE;
    else if (clk_en) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = DECODE;
      DECODE:  state_d = (is_spec || sh_w == 10'sd0) ? FIN : SHIFT;
      SHIFT:   if (rem_q == k_w) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q     <= '0;
      mag_q      <= '0;
      spec_val_q <= '0;
      spec_q     <= 1'b0;
      left_q     <= 1'b0;
      rem_q      <= '0;
      result     <= '0;
      done       <= 1'b0;
    end else if (clk_en) begin
      done <= (state_q == FIN);
      case (state_q)
        IDLE: if (start) data_q <= dataa;
        DECODE: begin
          spec_q     <= is_spec;
          spec_val_q <= spec_val;
          mag_q      <= {8'h00, 1'b1, frac_w};
          rem_q      <= sh_abs_w;
          left_q     <= ~sh_w[9];
        end
        SHIFT: begin
          mag_q <= left_q ? (mag_q << k_w) : (mag_q >> k_w);
          rem_q <= rem_q - k_w;
        end
        FIN: result <= spec_q ? spec_val_q : (sign_w ? -mag_q : mag_q);
        default: ;
      endcase
    end
  end

endmodule
